// File: rtl/cave_input_mapper_if.sv
// ---------------------------------------------------------------------------
// cave_input_mapper_if
//   Bundles the player-input signals exchanged between the hps_io side and
//   the cave top level.
//   master : drives ps2_key / joystick / autofire_en, receives decoded controls
//   slave  : the mapper; receives raw inputs, drives the registered controls
//   ps2_key      [10] toggle-per-event, [9] pressed, [8] extended, [7:0] code
//   joystick     32 bits per player, player p at [32p+31:32p]
//   autofire_en  bit p*NUM_BUTTONS+b enables autofire on player p button b
//   up/down/left/right/start/coin/pause/service  bit p = player p
//   buttons      bit p*NUM_BUTTONS+b = player p button b
// ---------------------------------------------------------------------------
interface cave_input_mapper_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_BUTTONS = 3
);
    logic [10:0]                          ps2_key;
    logic [32*NUM_PLAYERS-1:0]            joystick;
    logic [NUM_PLAYERS*NUM_BUTTONS-1:0]   autofire_en;
    logic [NUM_PLAYERS-1:0]               up;
    logic [NUM_PLAYERS-1:0]               down;
    logic [NUM_PLAYERS-1:0]               left;
    logic [NUM_PLAYERS-1:0]               right;
    logic [NUM_PLAYERS*NUM_BUTTONS-1:0]   buttons;
    logic [NUM_PLAYERS-1:0]               start;
    logic [NUM_PLAYERS-1:0]               coin;
    logic [NUM_PLAYERS-1:0]               pause;
    logic [NUM_PLAYERS-1:0]               service;

    modport master (
        output ps2_key, joystick, autofire_en,
        input  up, down, left, right, buttons, start, coin, pause, service
    );

    modport slave (
        input  ps2_key, joystick, autofire_en,
        output up, down, left, right, buttons, start, coin, pause, service
    );
endinterface

// File: rtl/cave_input_mapper.sv
// ---------------------------------------------------------------------------
// cave_input_mapper
//   Maps hps_io PS/2 key events and joystick words onto per-player controls.
//   Keys set/clear a latch per mapped key (P1/P2 only); the latch is OR'd
//   with the joystick word, then one register stage applies opposite
//   direction cleaning, per-button autofire and coin pulse stretching.
//   clk    system clock
//   rst_n  asynchronous active-low reset, released synchronously to clk
//   bus    cave_input_mapper_if.slave (raw inputs in, registered controls out)
// ---------------------------------------------------------------------------
module cave_input_mapper #(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_BUTTONS  = 3,
    parameter int SOCD_CLEAN   = 1,
    parameter int AUTOFIRE_DIV = 2048,
    parameter int COIN_PULSE   = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cave_input_mapper_if.slave   bus
);
    localparam int  NP    = NUM_PLAYERS;
    localparam int  NB    = NUM_BUTTONS;
    localparam int  W     = NB + 8;
    localparam int  AF_W  = $clog2(AUTOFIRE_DIV);
    localparam int  CNT_W = $clog2(COIN_PULSE + 1);
    localparam bit  SOCD  = (SOCD_CLEAN != 0);

    // Key latch slot order (independent of NUM_BUTTONS)
    localparam logic [3:0] F_RIGHT = 4'd0, F_LEFT = 4'd1, F_DOWN  = 4'd2, F_UP    = 4'd3,
                           F_B0    = 4'd4, F_B1   = 4'd5, F_B2    = 4'd6, F_START = 4'd7,
                           F_COIN  = 4'd8, F_PAUSE = 4'd9, F_SERVICE = 4'd10;

    logic             prev;
    logic             armed;
    logic [10:0]      key_lat [2];
    logic [AF_W-1:0]  af_cnt;
    logic             phase;
    logic [NP-1:0]    coin_prev;
    logic [CNT_W-1:0] cnt [NP];

    logic             hit;
    logic             kp;
    logic [3:0]       kf;
    logic             kvalid;
    logic             key_evt;

    logic [W-1:0]     raw [NP];
    logic [NP-1:0]    up_d, down_d, left_d, right_d, start_d, coin_d, pause_d, service_d;
    logic [NP*NB-1:0] btn_d;
    logic [CNT_W-1:0] cnt_d [NP];
    logic [NP-1:0]    coin_edge;

    logic [NP-1:0]    up_p1, down_p1, left_p1, right_p1, start_p1, coin_p1, pause_p1, service_p1;
    logic [NP*NB-1:0] btn_p1;

    // Key latch slots and joystick bits that a given configuration never reads
    logic unused_bits;
    assign unused_bits = ^{bus.joystick, key_lat[0], key_lat[1]};

    // Armed blocks the first cycle after reset so a stale ps2_key[10]
    // level is absorbed into prev instead of replaying the last key.
    assign key_evt = armed & (bus.ps2_key[10] ^ prev);

    always_comb begin
        hit = 1'b0;
        kp  = 1'b0;
        kf  = F_RIGHT;
        if (bus.ps2_key[8]) begin
            unique case (bus.ps2_key[7:0])
                8'h75:   begin hit = 1'b1; kf = F_UP;    end
                8'h72:   begin hit = 1'b1; kf = F_DOWN;  end
                8'h6B:   begin hit = 1'b1; kf = F_LEFT;  end
                8'h74:   begin hit = 1'b1; kf = F_RIGHT; end
                8'h14:   begin hit = 1'b1; kf = F_B0;    end
                8'h11:   begin hit = 1'b1; kf = F_B1;    end
                default: hit = 1'b0;
            endcase
        end else begin
            unique case (bus.ps2_key[7:0])
                8'h14:   begin hit = 1'b1; kf = F_B0;      end
                8'h11:   begin hit = 1'b1; kf = F_B1;      end
                8'h29:   begin hit = 1'b1; kf = F_B2;      end
                8'h16:   begin hit = 1'b1; kf = F_START;   end
                8'h2E:   begin hit = 1'b1; kf = F_COIN;    end
                8'h4D:   begin hit = 1'b1; kf = F_PAUSE;   end
                8'h46:   begin hit = 1'b1; kf = F_SERVICE; end
                8'h2D:   begin hit = 1'b1; kp = 1'b1; kf = F_UP;      end
                8'h2B:   begin hit = 1'b1; kp = 1'b1; kf = F_DOWN;    end
                8'h23:   begin hit = 1'b1; kp = 1'b1; kf = F_LEFT;    end
                8'h34:   begin hit = 1'b1; kp = 1'b1; kf = F_RIGHT;   end
                8'h1C:   begin hit = 1'b1; kp = 1'b1; kf = F_B0;      end
                8'h1B:   begin hit = 1'b1; kp = 1'b1; kf = F_B1;      end
                8'h15:   begin hit = 1'b1; kp = 1'b1; kf = F_B2;      end
                8'h1E:   begin hit = 1'b1; kp = 1'b1; kf = F_START;   end
                8'h36:   begin hit = 1'b1; kp = 1'b1; kf = F_COIN;    end
                8'h45:   begin hit = 1'b1; kp = 1'b1; kf = F_SERVICE; end
                default: hit = 1'b0;
            endcase
        end
        kvalid = hit && (int'(kp) < NP) &&
                 !((kf >= F_B0) && (kf <= F_B2) && ((int'(kf) - 4) >= NB));
    end

    always_comb begin
        up_d = '0; down_d = '0; left_d = '0; right_d = '0;
        start_d = '0; coin_d = '0; pause_d = '0; service_d = '0;
        btn_d = '0; coin_edge = '0;
        for (int p = 0; p < NP; p++) begin
            raw[p]   = bus.joystick[32*p +: W];
            cnt_d[p] = '0;
            if (p < 2) begin
                raw[p][3:0]  = raw[p][3:0] | key_lat[1'(p)][3:0];
                for (int b = 0; b < NB; b++)
                    if (b < 3) raw[p][4+b] = raw[p][4+b] | key_lat[1'(p)][4+b];
                raw[p][NB+4] = raw[p][NB+4] | key_lat[1'(p)][F_START];
                raw[p][NB+5] = raw[p][NB+5] | key_lat[1'(p)][F_COIN];
                raw[p][NB+6] = raw[p][NB+6] | key_lat[1'(p)][F_PAUSE];
                raw[p][NB+7] = raw[p][NB+7] | key_lat[1'(p)][F_SERVICE];
            end
            up_d[p]    = raw[p][3] & ~(SOCD & raw[p][2]);
            down_d[p]  = raw[p][2] & ~(SOCD & raw[p][3]);
            left_d[p]  = raw[p][1] & ~(SOCD & raw[p][0]);
            right_d[p] = raw[p][0] & ~(SOCD & raw[p][1]);
            for (int b = 0; b < NB; b++)
                btn_d[p*NB+b] = raw[p][4+b] & (bus.autofire_en[p*NB+b] ? phase : 1'b1);
            start_d[p]   = raw[p][NB+4];
            pause_d[p]   = raw[p][NB+6];
            service_d[p] = raw[p][NB+7];
            coin_edge[p] = raw[p][NB+5] & ~coin_prev[p];
            coin_d[p]    = raw[p][NB+5] | (cnt[p] != '0) | coin_edge[p];
            if (coin_edge[p])
                cnt_d[p] = CNT_W'(COIN_PULSE - 1);
            else if (cnt[p] != '0)
                cnt_d[p] = cnt[p] - CNT_W'(1);
        end
    end

    // Stage boundary: key latches / counters and the stage-1 output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= 1'b0;
            armed      <= 1'b0;
            key_lat[0] <= '0;
            key_lat[1] <= '0;
            af_cnt     <= '0;
            phase      <= 1'b0;
            coin_prev  <= '0;
            for (int p = 0; p < NP; p++) cnt[p] <= '0;
            up_p1 <= '0; down_p1 <= '0; left_p1 <= '0; right_p1 <= '0;
            start_p1 <= '0; coin_p1 <= '0; pause_p1 <= '0; service_p1 <= '0;
            btn_p1 <= '0;
        end else begin
            prev  <= bus.ps2_key[10];
            armed <= 1'b1;
            if (key_evt && kvalid)
                key_lat[kp][kf] <= bus.ps2_key[9];
            if (af_cnt == AF_W'(AUTOFIRE_DIV - 1)) begin
                af_cnt <= '0;
                phase  <= ~phase;
            end else begin
                af_cnt <= af_cnt + AF_W'(1);
            end
            for (int p = 0; p < NP; p++) begin
                coin_prev[p] <= raw[p][NB+5];
                cnt[p]       <= cnt_d[p];
            end
            up_p1 <= up_d; down_p1 <= down_d; left_p1 <= left_d; right_p1 <= right_d;
            start_p1 <= start_d; coin_p1 <= coin_d; pause_p1 <= pause_d; service_p1 <= service_d;
            btn_p1 <= btn_d;
        end
    end

    assign bus.up      = up_p1;
    assign bus.down    = down_p1;
    assign bus.left    = left_p1;
    assign bus.right   = right_p1;
    assign bus.buttons = btn_p1;
    assign bus.start   = start_p1;
    assign bus.coin    = coin_p1;
    assign bus.pause   = pause_p1;
    assign bus.service = service_p1;
endmodule
